booth_product_accumulator: RTL and testbench
============================================

// Module: booth_product_accumulator
// PURPOSE
//  Downstream consumer of the 32x32 signed Booth multiplier's 64-bit product.
//  Accepts one signed product per cycle over a valid/ready handshake and sums the products into a wide signed accumulator.
//  Saturates or wraps on overflow. Presents the dot-product result, the term count and a sticky overflow flag on an output handshake.
//  Forms the accumulate half of the team's MAC datapath.
// PARAMETERS
//  PROD_W    64  width of incoming signed product (matches multiplier output)
//  ACC_W     72  accumulator width; ACC_W >= PROD_W is required (elaboration error otherwise)
//  CNT_W     16  width of accepted-term counter
//  SATURATE  1   1 = clamp at signed max/min on overflow; 0 = two's-complement wrap
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  clear        in   1        synchronous flush of accumulator/state
//  in_valid     in   1        in_product/in_last valid
//  in_ready     out  1        block can accept a product this cycle
//  in_product   in   PROD_W   signed product from multiplier
//  in_last      in   1        marks final term of current sum
//  out_valid    out  1        result valid
//  out_ready    in   1        downstream accepts result
//  out_acc      out  ACC_W    signed accumulated sum
//  out_count    out  CNT_W    number of terms accepted into this sum
//  out_overflow out  1        sticky: any overflow occurred during this sum
// BEHAVIOUR
//  Reset:
//   - rst=1 forces the following immediately (no clock needed): state=ACCUM, acc=0, count=0, overflow=0, out_valid=0.
//   - in_ready follows from state and is 1 after rst deasserts.
//   - Reset mid-sum or mid-drain discards all data.
//  FSM, 2 states:
//   - ACCUM:
//     - in_ready = !clear.
//     - Accept when in_valid && in_ready: acc <= acc + sext(in_product); count <= count+1.
//     - count saturates at all-ones.
//     - If in_last is also 1, go to DRAIN.
//   - DRAIN:
//     - out_valid=1, in_ready=0.
//     - When out_valid && out_ready: acc, count and overflow <= 0; go to ACCUM.
//  Latency:
//   - A product accepted at edge N is reflected in out_acc after edge N.
//   - If that product carries in_last, out_valid is 1 in the cycle after edge N.
//   - Throughput is 1 term/cycle.
//   - Minimum of 1 idle input cycle per sum (the drain handshake cycle).
//  Output stability: out_acc, out_count and out_overflow are held constant while out_valid && !out_ready.
//  Outputs are registered; out_acc shows the running sum in ACCUM.
//  Arithmetic:
//   - Sum is computed at ACC_W+1 bits.
//   - Signed overflow = the top two bits of the ACC_W+1-bit sum differ.
//   - On overflow, overflow <= 1 (sticky until drain or clear).
//   - SATURATE=1: acc <= 2^(ACC_W-1)-1 on positive overflow, -2^(ACC_W-1) on negative overflow.
//   - SATURATE=0: acc <= low ACC_W bits of the sum.
//   - Once saturated, further terms add normally from the clamped value.
//  clear:
//   - Priority is below rst and above all other inputs.
//   - Next edge: acc=0, count=0, overflow=0, state=ACCUM, out_valid=0.
//   - A pending DRAIN result is dropped.
//   - in_valid in the same cycle is not accepted (in_ready=0).
//  Single-term sum: in_valid && in_last in ACCUM with count=0 gives a result equal to sext(in_product) with count=1.
//  In DRAIN, in_valid is ignored and the upstream holds its data because in_ready=0.
// TESTING
//  T1 Reset: assert rst -> out_valid=0, out_acc=0, out_count=0, out_overflow=0. Release -> in_ready=1.
//  T2 Sum: products 6, -20, 100 (last on third), out_ready=1 -> out_valid 1 cycle after the 3rd accept; out_acc=86, out_count=3, out_overflow=0.
//  T3 Backpressure: after T2, hold out_ready=0 for 5 cycles.
//   -> in_ready=0 and out_acc=86 held stable throughout.
//   -> Raise out_ready: one handshake, then out_acc=0 and in_ready=1 on the next cycle.
//  T4 Overflow (ACC_W=64): 0x7FFF_FFFF_FFFF_FFFF then 1 (last).
//   -> SATURATE=1: out_acc=0x7FFF_FFFF_FFFF_FFFF, out_overflow=1.
//   -> SATURATE=0: out_acc=0x8000_0000_0000_0000, out_overflow=1.
//  T5 Clear in DRAIN: out_valid=1, out_ready=0, pulse clear with in_valid=1.
//   -> Next cycle out_valid=0, out_acc=0, out_count=0; that input is not accepted.
//  T6 Async reset mid-sum: after 2 accepted terms, assert rst between clock edges.
//   -> out_acc and out_count read 0 before the next edge; the next sum starts from 0.

Source files
------------

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Sums a stream of signed multiplier products into a wide signed accumulator.
// Overflow either saturates or wraps, and a sticky flag records it. The finished
// sum, its term count and the overflow flag are offered on an output handshake.
// The block takes one term per cycle and needs one drain cycle per sum.
module booth_product_accumulator #(
    parameter int PROD_W   = 64,
    parameter int ACC_W    = 72,
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PROD_W-1:0] in_product_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_acc_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_overflow_o
);

    // The accumulator must hold at least one full product.
    generate
        if (ACC_W < PROD_W) begin : g_width_check
            $error("booth_product_accumulator: ACC_W must be >= PROD_W");
        end
    endgenerate

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               valid_q;

    logic [ACC_W:0]     sum_full;
    logic               sum_ovf;
    logic               accept;
    logic               drain_fire;

    // clear blocks acceptance in the same cycle so a flushed term is never counted.
    assign in_ready_o = (state_q == ST_ACCUM) && !clear_i;
    assign accept     = in_valid_i && in_ready_o;
    assign drain_fire = valid_q && out_ready_i;

    // One guard bit above the accumulator. When the top two bits differ, the true
    // sum does not fit in ACC_W bits.
    assign sum_full = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W+1-PROD_W){in_product_i[PROD_W-1]}}, in_product_i};
    assign sum_ovf  = sum_full[ACC_W] ^ sum_full[ACC_W-1];

    // Next accumulator, count and overflow values for an accepted term.
    always_comb begin
        acc_d = sum_full[ACC_W-1:0];
        if (SATURATE && sum_ovf) begin
            // The guard bit holds the true sign, so it selects which rail to clamp to.
            acc_d = sum_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
        ovf_d   = ovf_q | sum_ovf;
        count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
    end

    // Two-state control with registered outputs. Outputs freeze in DRAIN until the handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        ovf_q   <= ovf_d;
                        if (in_last_i) begin
                            state_q <= ST_DRAIN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_fire) begin
                        state_q <= ST_ACCUM;
                        acc_q   <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o    = valid_q;
    assign out_acc_o      = acc_q;
    assign out_count_o    = count_q;
    assign out_overflow_o = ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator. Three instances share one stimulus stream:
//   0: ACC_W=72, CNT_W=16, saturating
//   1: ACC_W=64, CNT_W=4,  saturating
//   2: ACC_W=64, CNT_W=4,  wrapping
// Each instance is checked against an ideal-arithmetic model of the sum.
module tb_booth_product_accumulator;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [63:0] in_product;
    logic        in_last;
    logic        out_ready;

    logic        rdy [3];
    logic        vld [3];
    logic        ovf [3];
    logic [71:0] acc_w;
    logic [63:0] acc_s;
    logic [63:0] acc_r;
    logic [15:0] cnt_w;
    logic [3:0]  cnt_s;
    logic [3:0]  cnt_r;

    logic signed [127:0] act_acc [3];
    logic [31:0]         act_cnt [3];

    booth_product_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16), .SATURATE(1'b1)) u_wide (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .in_product_i(in_product), .in_last_i(in_last), .out_valid_o(vld[0]), .out_ready_i(out_ready),
        .out_acc_o(acc_w), .out_count_o(cnt_w), .out_overflow_o(ovf[0]));

    booth_product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(4), .SATURATE(1'b1)) u_nsat (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .in_product_i(in_product), .in_last_i(in_last), .out_valid_o(vld[1]), .out_ready_i(out_ready),
        .out_acc_o(acc_s), .out_count_o(cnt_s), .out_overflow_o(ovf[1]));

    booth_product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(4), .SATURATE(1'b0)) u_nwrap (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
        .in_product_i(in_product), .in_last_i(in_last), .out_valid_o(vld[2]), .out_ready_i(out_ready),
        .out_acc_o(acc_r), .out_count_o(cnt_r), .out_overflow_o(ovf[2]));

    assign act_acc[0] = {{56{acc_w[71]}}, acc_w};
    assign act_acc[1] = {{64{acc_s[63]}}, acc_s};
    assign act_acc[2] = {{64{acc_r[63]}}, acc_r};
    assign act_cnt[0] = {16'd0, cnt_w};
    assign act_cnt[1] = {28'd0, cnt_s};
    assign act_cnt[2] = {28'd0, cnt_r};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: ideal integer sum, then apply the overflow rule per configuration.
    logic signed [127:0] m_acc [3];
    int                  m_cnt [3];
    logic                m_ovf [3];
    logic                m_drain;

    function automatic logic signed [127:0] acc_max(input int k);
        logic signed [127:0] one;
        int w;
        one = 128'sd1;
        w   = (k == 0) ? 72 : 64;
        return (one <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = '0;
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
        end
        m_drain = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic signed [63:0] p, input logic last,
                              input logic ordy, input logic clr);
        logic signed [127:0] s;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        logic signed [127:0] ps;
        if (clr) begin
            model_reset();
        end else if (!m_drain && v) begin
            ps = p;
            for (int k = 0; k < 3; k++) begin
                hi = acc_max(k);
                lo = -hi - 128'sd1;
                s  = m_acc[k] + ps;
                if (s > hi) begin
                    m_ovf[k] = 1'b1;
                    m_acc[k] = (k != 2) ? hi : s - 2 * (hi + 1);
                end else if (s < lo) begin
                    m_ovf[k] = 1'b1;
                    m_acc[k] = (k != 2) ? lo : s + 2 * (hi + 1);
                end else begin
                    m_acc[k] = s;
                end
                if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
            end
            if (last) m_drain = 1'b1;
        end else if (m_drain && ordy) begin
            model_reset();
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s acc[%0d]", tag, k), act_acc[k], m_acc[k]);
            chk($sformatf("%s count[%0d]", tag, k), 128'(act_cnt[k]), 128'(m_cnt[k]));
            chk($sformatf("%s overflow[%0d]", tag, k), 128'(ovf[k]), 128'(m_ovf[k]));
            chk($sformatf("%s out_valid[%0d]", tag, k), 128'(vld[k]), 128'(m_drain));
        end
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge, then check outputs after it.
    task automatic cycle(input logic v, input logic signed [63:0] p, input logic last,
                         input logic ordy, input logic clr, input string tag, output logic pre_rdy);
        in_valid   = v;
        in_product = p;
        in_last    = last;
        out_ready  = ordy;
        clear      = clr;
        #1;
        pre_rdy = rdy[0];
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s in_ready[%0d]", tag, k), 128'(rdy[k]), 128'(!m_drain && !clr));
        if (m_drain && ordy && !clr)
            $display("txn %s: result acc=%0d count=%0d ovf=%0d", tag, m_acc[0], m_cnt[0], m_ovf[0]);
        else if (!m_drain && v && !clr)
            $display("txn %s: term %0d last=%0d", tag, p, last);
        @(posedge clk);
        #1;
        model_edge(v, p, last, ordy, clr);
        check_model(tag);
    endtask

    typedef struct {
        logic                v;
        logic signed [63:0]  p;
        logic                last;
        logic                ordy;
        logic                exp_rdy;
        logic signed [127:0] exp_acc;
        int                  exp_cnt;
        logic                exp_vld;
    } vec_t;

    vec_t tbl [10];
    logic pr;
    logic signed [63:0] maxp;
    logic signed [63:0] rp;

    initial begin
        tbl[0] = '{1'b1, 64'sd6,    1'b0, 1'b1, 1'b1, 128'sd6,   1, 1'b0};
        tbl[1] = '{1'b1, -64'sd20,  1'b0, 1'b1, 1'b1, -128'sd14, 2, 1'b0};
        tbl[2] = '{1'b1, 64'sd100,  1'b1, 1'b0, 1'b1, 128'sd86,  3, 1'b1};
        for (int i = 3; i < 8; i++)
            tbl[i] = '{1'b1, 64'sd555, 1'b0, 1'b0, 1'b0, 128'sd86, 3, 1'b1};
        tbl[8] = '{1'b1, 64'sd555,  1'b0, 1'b1, 1'b0, 128'sd0,   0, 1'b0};
        tbl[9] = '{1'b0, 64'sd0,    1'b0, 1'b1, 1'b1, 128'sd0,   0, 1'b0};

        // Reset check: outputs must be zero before any clock edge.
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        check_model("T1 reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("T1 in_ready after reset", 128'(rdy[0]), 128'(1'b1));

        // Three-term sum, then backpressure and a single drain handshake.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].p, tbl[i].last, tbl[i].ordy, 1'b0, $sformatf("T2/3 row%0d", i), pr);
            chk($sformatf("row%0d in_ready", i), 128'(pr), 128'(tbl[i].exp_rdy));
            chk($sformatf("row%0d out_acc", i), act_acc[0], tbl[i].exp_acc);
            chk($sformatf("row%0d out_count", i), 128'(act_cnt[0]), 128'(tbl[i].exp_cnt));
            chk($sformatf("row%0d out_valid", i), 128'(vld[0]), 128'(tbl[i].exp_vld));
        end

        // Overflow at 64 bits: saturate clamps, wrap wraps, and the 72-bit sum stays exact.
        maxp = 64'sh7FFF_FFFF_FFFF_FFFF;
        cycle(1'b1, maxp, 1'b0, 1'b0, 1'b0, "T4 a", pr);
        cycle(1'b1, 64'sd1, 1'b1, 1'b0, 1'b0, "T4 b", pr);
        chk("T4 sat acc", act_acc[1], 128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF);
        chk("T4 sat ovf", 128'(ovf[1]), 128'(1'b1));
        chk("T4 wrap acc", act_acc[2], 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
        chk("T4 wrap ovf", 128'(ovf[2]), 128'(1'b1));
        chk("T4 wide acc", act_acc[0], 128'h0000_0000_0000_0000_8000_0000_0000_0000);
        chk("T4 wide ovf", 128'(ovf[0]), 128'(1'b0));

        // Clear while in DRAIN drops the result and refuses the offered term.
        cycle(1'b1, 64'sd77, 1'b0, 1'b0, 1'b1, "T5 clear", pr);
        chk("T5 in_ready", 128'(pr), 128'(1'b0));
        chk("T5 out_valid", 128'(vld[0]), 128'(1'b0));
        chk("T5 out_acc", act_acc[0], 128'sd0);
        chk("T5 out_count", 128'(act_cnt[0]), 128'd0);
        cycle(1'b1, 64'sd5, 1'b1, 1'b0, 1'b0, "T5 single", pr);
        chk("T5 single acc", act_acc[0], 128'sd5);
        chk("T5 single count", 128'(act_cnt[0]), 128'd1);
        cycle(1'b0, 64'sd0, 1'b0, 1'b1, 1'b0, "T5 drain", pr);

        // Asynchronous reset between edges after two accepted terms.
        cycle(1'b1, 64'sd1000, 1'b0, 1'b1, 1'b0, "T6 a", pr);
        cycle(1'b1, 64'sd2000, 1'b0, 1'b1, 1'b0, "T6 b", pr);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("T6 async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, -64'sd42, 1'b1, 1'b0, 1'b0, "T6 restart", pr);
        chk("T6 restart acc", act_acc[0], -128'sd42);
        chk("T6 restart count", 128'(act_cnt[0]), 128'd1);
        cycle(1'b0, 64'sd0, 1'b0, 1'b1, 1'b0, "T6 drain", pr);

        // Drive the 72-bit sum past its rail. Also saturates the 4-bit counters.
        for (int i = 0; i < 259; i++)
            cycle(1'b1, maxp, 1'b0, 1'b1, 1'b0, "SAT fill", pr);
        cycle(1'b1, -64'sd5, 1'b1, 1'b0, 1'b0, "SAT tail", pr);
        chk("SAT wide acc", act_acc[0], 128'h0000_0000_0000_007F_FFFF_FFFF_FFFF_FFFA);
        chk("SAT wide ovf", 128'(ovf[0]), 128'(1'b1));
        chk("SAT wide count", 128'(act_cnt[0]), 128'd260);
        chk("SAT narrow acc", act_acc[1], 128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFA);
        chk("SAT narrow count", 128'(act_cnt[1]), 128'd15);
        cycle(1'b0, 64'sd0, 1'b0, 1'b1, 1'b0, "SAT drain", pr);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) rp = {$urandom, $urandom};
            else rp = 64'(signed'(32'($urandom_range(0, 2000)) - 32'sd1000));
            cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                  $sformatf("RND%0d", i), pr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
